// File: rtl/lcd_frame_serializer.sv
// Snapshots the processor debug bus on start and streams it out as a framed, XOR-checksummed byte sequence.
// Optional LCD_FRAME_SEQ_EN inserts a wrapping 8-bit frame sequence byte right after the header.
module lcd_frame_serializer #(
  parameter int          NREGS  = 32,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                 clk_2,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           lcd_pc,
  input  logic [7:0]           lcd_SrcA,
  input  logic [7:0]           lcd_SrcB,
  input  logic [7:0]           lcd_ALUResult,
  input  logic [7:0]           lcd_Result,
  input  logic [7:0]           lcd_WriteData,
  input  logic [7:0]           lcd_ReadData,
  input  logic [31:0]          lcd_instruction,
  input  logic                 lcd_MemWrite,
  input  logic                 lcd_Branch,
  input  logic                 lcd_MemtoReg,
  input  logic                 lcd_RegWrite,
  input  logic [8*NREGS-1:0]   lcd_registrador,
  input  logic [63:0]          lcd_a,
  input  logic [63:0]          lcd_b,
  input  logic [7:0]           LED,
  input  logic [7:0]           SEG,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 frame_done
);

`ifdef LCD_FRAME_SEQ_EN
  localparam int OFS = 1;
  logic [7:0] seq_q;
`else
  localparam int OFS = 0;
`endif

  // Payload is everything between header and checksum.
  localparam int         PAYLOAD   = 30 + NREGS + OFS;
  localparam int         FRAME_LEN = PAYLOAD + 2;
  localparam logic [8:0] LAST_IDX  = 9'(FRAME_LEN - 1);
  localparam logic [8:0] CSUM_IDX  = 9'(FRAME_LEN - 2);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q;
  logic [8:0] idx_q;
  logic [7:0] csum_q;
  logic [7:0] csum_d;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       busy_q;
  logic       frame_done_q;
  logic [7:0] snap_q    [PAYLOAD];
  logic [7:0] payload_d [PAYLOAD];

  assign csum_d = csum_q ^ tx_data_q;

  always_comb begin
    for (int k = 0; k < PAYLOAD; k++) payload_d[k] = '0;
`ifdef LCD_FRAME_SEQ_EN
    payload_d[0] = seq_q;
`endif
    payload_d[OFS + 0] = lcd_pc;
    for (int j = 0; j < 4; j++) payload_d[OFS + 1 + j] = lcd_instruction[31 - 8*j -: 8];
    payload_d[OFS + 5]  = lcd_SrcA;
    payload_d[OFS + 6]  = lcd_SrcB;
    payload_d[OFS + 7]  = lcd_ALUResult;
    payload_d[OFS + 8]  = lcd_Result;
    payload_d[OFS + 9]  = lcd_WriteData;
    payload_d[OFS + 10] = lcd_ReadData;
    payload_d[OFS + 11] = {4'b0, lcd_RegWrite, lcd_MemtoReg, lcd_Branch, lcd_MemWrite};
    for (int i = 0; i < NREGS; i++) payload_d[OFS + 12 + i] = lcd_registrador[8*i +: 8];
    for (int j = 0; j < 8; j++) begin
      payload_d[OFS + 12 + NREGS + j] = lcd_a[63 - 8*j -: 8];
      payload_d[OFS + 20 + NREGS + j] = lcd_b[63 - 8*j -: 8];
    end
    payload_d[OFS + 28 + NREGS] = LED;
    payload_d[OFS + 29 + NREGS] = SEG;
  end

  // snap_q[0] always holds the byte that follows the one currently on tx_data.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      csum_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < PAYLOAD; k++) snap_q[k] <= '0;
`ifdef LCD_FRAME_SEQ_EN
      seq_q        <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < PAYLOAD; k++) snap_q[k] <= payload_d[k];
            idx_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            csum_q <= csum_d;
            idx_q  <= idx_q + 9'd1;
            for (int k = 0; k < PAYLOAD - 1; k++) snap_q[k] <= snap_q[k + 1];
            snap_q[PAYLOAD - 1] <= '0;
            if (idx_q == LAST_IDX) begin
              state_q      <= IDLE;
              tx_valid_q   <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              tx_data_q    <= '0;
`ifdef LCD_FRAME_SEQ_EN
              seq_q        <= seq_q + 8'd1;
`endif
            end else if (idx_q == CSUM_IDX) begin
              tx_data_q <= csum_d;
            end else begin
              tx_data_q <= snap_q[0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_serializer.sv
// Scoreboard bench for lcd_frame_serializer: expected frames are queued at start and popped per handshake.
module tb_lcd_frame_serializer;
  localparam int NREGS = 32;
`ifdef LCD_FRAME_SEQ_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int LEN = 32 + NREGS + OFS;

  logic clk_2, rst_n, start, tx_ready;
  logic [7:0] pc, srca, srcb, alu, res, wd, rd, led, seg;
  logic [31:0] instr;
  logic mw, br, m2r, rw;
  logic [8*NREGS-1:0] regs;
  logic [63:0] la, lb;
  logic [7:0] tx_data;
  logic tx_valid, busy, frame_done;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq;
  logic [7:0] rx [LEN];
  logic [7:0] rx_prev [LEN];
  int rx_n;

  lcd_frame_serializer #(.NREGS(NREGS), .HEADER(8'hA5)) dut (
    .clk_2(clk_2), .rst_n(rst_n), .start(start),
    .lcd_pc(pc), .lcd_SrcA(srca), .lcd_SrcB(srcb), .lcd_ALUResult(alu),
    .lcd_Result(res), .lcd_WriteData(wd), .lcd_ReadData(rd),
    .lcd_instruction(instr), .lcd_MemWrite(mw), .lcd_Branch(br),
    .lcd_MemtoReg(m2r), .lcd_RegWrite(rw), .lcd_registrador(regs),
    .lcd_a(la), .lcd_b(lb), .LED(led), .SEG(seg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic set_zero();
    {pc, srca, srcb, alu, res, wd, rd, led, seg} = '0;
    instr = '0; {mw, br, m2r, rw} = '0; regs = '0; la = '0; lb = '0;
  endtask

  task automatic set_random();
    pc = 8'($urandom); srca = 8'($urandom); srcb = 8'($urandom); alu = 8'($urandom);
    res = 8'($urandom); wd = 8'($urandom); rd = 8'($urandom);
    led = 8'($urandom); seg = 8'($urandom); instr = $urandom;
    {mw, br, m2r, rw} = 4'($urandom);
    for (int i = 0; i < NREGS; i++) regs[8*i +: 8] = 8'($urandom);
    la = {$urandom, $urandom}; lb = {$urandom, $urandom};
  endtask

  // Reference frame built from the field list, queued at the moment start is driven.
  task automatic push_frame();
    logic [7:0] b[$];
    logic [7:0] cs;
    b.push_back(8'hA5);
`ifdef LCD_FRAME_SEQ_EN
    b.push_back(exp_seq);
`endif
    b.push_back(pc);
    b.push_back(instr[31:24]); b.push_back(instr[23:16]);
    b.push_back(instr[15:8]);  b.push_back(instr[7:0]);
    b.push_back(srca); b.push_back(srcb); b.push_back(alu);
    b.push_back(res);  b.push_back(wd);   b.push_back(rd);
    b.push_back({4'b0, rw, m2r, br, mw});
    for (int i = 0; i < NREGS; i++) b.push_back(regs[8*i +: 8]);
    for (int j = 7; j >= 0; j--) b.push_back(la[8*j +: 8]);
    for (int j = 7; j >= 0; j--) b.push_back(lb[8*j +: 8]);
    b.push_back(led); b.push_back(seg);
    cs = '0;
    foreach (b[i]) cs ^= b[i];
    b.push_back(cs);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic pulse_start();
    start = 1'b1;
    push_frame();
    @(negedge clk_2);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || tx_valid !== 1'b1)
      begin bad++; $display("FAIL start_resp got busy=%b valid=%b exp 1 1", busy, tx_valid); end
    total++;
    if (tx_data !== 8'hA5)
      begin bad++; $display("FAIL header got=%h exp=a5", tx_data); end
  endtask

  task automatic drain(input bit stall, input bit poke, output int cyc);
    logic [7:0] held, e;
    bit hold_chk, done;
    hold_chk = 0; done = 0; cyc = 0; rx_n = 0; held = '0;
    while (!done) begin
      if (cyc > 4*LEN + 20) begin
        total++; bad++;
        $display("FAIL drain_timeout got cycles=%0d exp <=%0d", cyc, 4*LEN + 20);
        start = 1'b0;
        done = 1;
      end else begin
        if (hold_chk) begin
          total++;
          if (tx_data !== held)
            begin bad++; $display("FAIL hold got=%h exp=%h", tx_data, held); end
          hold_chk = 0;
        end
        if (frame_done === 1'b1) begin
          start = 1'b0;
          total++;
          if (busy !== 1'b0 || tx_valid !== 1'b0)
            begin bad++; $display("FAIL done_state got busy=%b valid=%b exp 0 0", busy, tx_valid); end
          total++;
          if (exp_q.size() != 0)
            begin bad++; $display("FAIL leftover got=%0d bytes pending exp=0", exp_q.size()); end
          exp_seq++;
          $display("frame done: cycles=%0d bytes=%0d", cyc, rx_n);
          done = 1;
        end else begin
          total++;
          if (busy !== 1'b1 || tx_valid !== 1'b1)
            begin bad++; $display("FAIL in_send got busy=%b valid=%b exp 1 1 at cyc %0d", busy, tx_valid, cyc); end
          tx_ready = stall ? cyc[0] : 1'b1;
          if (poke) begin
            start = (cyc == 10 || exp_q.size() == 1);
            if (cyc == 10) set_random();
          end
          if (tx_ready) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL extra_byte got=%h exp none", tx_data);
            end else begin
              e = exp_q.pop_front();
              total++;
              if (tx_data !== e)
                begin bad++; $display("FAIL byte%0d got=%h exp=%h", rx_n, tx_data, e); end
            end
            if (rx_n < LEN) rx[rx_n] = tx_data;
            rx_n++;
          end else begin
            held = tx_data;
            hold_chk = 1;
          end
          @(negedge clk_2);
          cyc++;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
    exp_q.delete(); exp_seq = '0;
    repeat (2) @(negedge clk_2);
    rst_n = 1'b1;
    @(negedge clk_2);
  endtask

  task automatic test_reset();
    set_zero();
    do_reset();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", frame_done); end
  endtask

  task automatic test_zero_frame();
    int cyc;
    set_zero();
    pulse_start();
    drain(0, 0, cyc);
    total++; if (cyc != LEN) begin bad++; $display("FAIL zero_len got=%0d exp=%0d", cyc, LEN); end
    total++; if (rx[LEN-1] !== 8'hA5) begin bad++; $display("FAIL zero_csum got=%h exp=a5", rx[LEN-1]); end
  endtask

  task automatic test_fields();
    int cyc;
    logic [7:0] f [6];
    set_random();
    pc = 8'h12; instr = 32'h34567890; srca = 8'hAB; regs[8*15 +: 8] = 8'hF0;
    f = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hAB};
    pulse_start();   // back-to-back with the previous frame_done
    drain(0, 0, cyc);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rx[OFS + 1 + i] !== f[i])
        begin bad++; $display("FAIL field_b%0d got=%h exp=%h", OFS + 1 + i, rx[OFS + 1 + i], f[i]); end
    end
    total++;
    if (rx[OFS + 28] !== 8'hF0) begin bad++; $display("FAIL reg15 got=%h exp=f0", rx[OFS + 28]); end
    for (int i = 0; i < LEN; i++) rx_prev[i] = rx[i];
  endtask

  task automatic test_backpressure();
    int cyc, diffs;
    pulse_start();
    drain(1, 0, cyc);
    tx_ready = 1'b1;
    total++;
    if (cyc != 2*LEN) begin bad++; $display("FAIL bp_len got=%0d exp=%0d", cyc, 2*LEN); end
    diffs = 0;
    for (int i = 0; i < LEN; i++)
      if (!(OFS == 1 && (i == 1 || i == LEN-1)) && rx[i] !== rx_prev[i]) diffs++;
    total++;
    if (diffs != 0) begin bad++; $display("FAIL bp_content got=%0d differing bytes exp=0", diffs); end
  endtask

  task automatic test_start_during_send();
    int cyc;
    set_random();
    pulse_start();
    drain(0, 1, cyc);
    total++; if (cyc != LEN) begin bad++; $display("FAIL poke_len got=%0d exp=%0d", cyc, LEN); end
    repeat (3) begin
      @(negedge clk_2);
      total++;
      if (tx_valid !== 1'b0 || busy !== 1'b0)
        begin bad++; $display("FAIL poke_idle got valid=%b busy=%b exp 0 0", tx_valid, busy); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    set_random();
    pulse_start();
    tx_ready = 1'b1;
    repeat (20) @(negedge clk_2);
    total++;
    if (tx_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b exp=1", tx_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL async_rst got valid=%b busy=%b exp 0 0", tx_valid, busy); end
    @(negedge clk_2);
    rst_n = 1'b1;
    exp_q.delete(); exp_seq = '0;
    @(negedge clk_2);
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL post_rst_idle got=%b exp=0", tx_valid); end
    set_random();
    pulse_start();
    drain(0, 0, cyc);
    total++; if (cyc != LEN) begin bad++; $display("FAIL post_rst_len got=%0d exp=%0d", cyc, LEN); end
  endtask

`ifdef LCD_FRAME_SEQ_EN
  task automatic test_seq();
    int cyc;
    logic [7:0] want;
    do_reset();
    for (int n = 0; n < 257; n++) begin
      want = 8'(n);
      set_random();
      pulse_start();
      drain(0, 0, cyc);
      total++;
      if (rx[1] !== want) begin bad++; $display("FAIL seq%0d got=%h exp=%h", n, rx[1], want); end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
    set_zero();
    test_reset();
    test_zero_frame();
    test_fields();
    test_backpressure();
    test_start_during_send();
    test_reset_mid_frame();
`ifdef LCD_FRAME_SEQ_EN
    test_seq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
